// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
// Source-side controller for a 4-phase req/ack multi-bit clock-domain crossing. One word is
// accepted per valid/ready handshake and held stable on xfer_data_o for the whole exchange.
// Only the acknowledge is synchronised; the data bus is sampled by the far side once it sees
// xfer_req_o high.
//
// Ports
//   clk_i             source-domain clock
//   rst_i             synchronous, active-high reset
//   in_valid_i        upstream word valid
//   in_ready_o        word can be accepted this cycle (combinational)
//   in_data_i         upstream word
//   xfer_data_o       registered word to far domain, stable while xfer_req_o=1
//   xfer_req_o        registered 4-phase request level
//   xfer_ack_async_i  far-domain acknowledge (asynchronous)
//   done_o            1-cycle pulse once ack has been seen low again
//   busy_o            controller is not idle (combinational)
//   timeout_err_o     sticky: an ack phase exceeded TIMEOUT_CYCLES (0 disables)
module cdc_handshake_tx #(
  parameter int unsigned DATA_WID       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_WID-1:0] in_data_i,
  output logic [DATA_WID-1:0] xfer_data_o,
  output logic                xfer_req_o,
  input  logic                xfer_ack_async_i,
  output logic                done_o,
  output logic                busy_o,
  output logic                timeout_err_o
);

  localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);
  // Counter only ever reaches TIMEOUT_CYCLES-1; keep at least one bit when disabled.
  localparam int unsigned CntW = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAckHi,
    StWaitAckLo,
    StFault
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_WID-1:0] data_q, data_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // Two-flop acknowledge synchroniser. Deliberately not reset so that a far-side ack that is
  // still high across a local reset keeps blocking new accepts until it really drops.
  logic [1:0] ack_sync_q = 2'b00;
  logic       ack_s;

  always_ff @(posedge clk_i) begin
    ack_sync_q <= {ack_sync_q[0], xfer_ack_async_i};
  end

  assign ack_s = ack_sync_q[1];

  logic timeout_hit;
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  assign in_ready_o = (state_q == StIdle) && !ack_s && !rst_i;
  assign busy_o     = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i && in_ready_o) begin
          data_d  = in_data_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = StWaitAckHi;
        end
      end
      StWaitAckHi: begin
        // A late ack on the expiry cycle still counts as a normal completion.
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWaitAckLo;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StFault;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitAckLo: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StFault;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFault: begin
        // Parked until reset; acknowledge activity is ignored.
        req_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign xfer_data_o   = data_q;
  assign xfer_req_o    = req_q;
  assign done_o        = done_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: three instances (timeout disabled, 8, 4) each driven by a
// far-side ack model that echoes xfer_req after a programmable delay or is forced to a level.
// Accepted words push their expected outcome (done cycle and data, or timeout cycle) into a
// per-instance queue; a negedge monitor pops on every done pulse or timeout_err rise.
module tb_cdc_handshake_tx;

  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 8;
  localparam int unsigned T2 = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       timeout;
    int         when;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       rst       [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic [7:0] xfer_data [3];
  logic       xfer_req  [3];
  logic       ack_async [3];
  logic       done      [3];
  logic       busy      [3];
  logic       tmo_err   [3];
  logic       prev_err  [3];

  // Far-side ack model controls.
  logic        ack_mode  [3];  // 0: echo req after ack_dly cycles, 1: drive ack_force
  logic        ack_force [3];
  int          ack_dly   [3];
  logic [31:0] req_hist  [3] = '{default: '0};

  exp_t sb_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) req_hist[i] <= {req_hist[i][30:0], xfer_req[i]};
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ack_async[i] = 1'b0;
      if (ack_mode[i]) ack_async[i] = ack_force[i];
      else if (ack_dly[i] == 0) ack_async[i] = xfer_req[i];
      else ack_async[i] = req_hist[i][ack_dly[i]-1];
    end
  end

  cdc_handshake_tx #(.DATA_WID(8), .TIMEOUT_CYCLES(T0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(in_data[0]), .xfer_data_o(xfer_data[0]), .xfer_req_o(xfer_req[0]),
    .xfer_ack_async_i(ack_async[0]), .done_o(done[0]), .busy_o(busy[0]),
    .timeout_err_o(tmo_err[0])
  );
  cdc_handshake_tx #(.DATA_WID(8), .TIMEOUT_CYCLES(T1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(in_data[1]), .xfer_data_o(xfer_data[1]), .xfer_req_o(xfer_req[1]),
    .xfer_ack_async_i(ack_async[1]), .done_o(done[1]), .busy_o(busy[1]),
    .timeout_err_o(tmo_err[1])
  );
  cdc_handshake_tx #(.DATA_WID(8), .TIMEOUT_CYCLES(T2)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_data_i(in_data[2]), .xfer_data_o(xfer_data[2]), .xfer_req_o(xfer_req[2]),
    .xfer_ack_async_i(ack_async[2]), .done_o(done[2]), .busy_o(busy[2]),
    .timeout_err_o(tmo_err[2])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int tmo_of(input int i);
    case (i)
      0:       return int'(T0);
      1:       return int'(T1);
      default: return int'(T2);
    endcase
  endfunction

  // Outcome of a word accepted at cycle c. Each phase the DUT sees ack_s d+2 cycles after
  // changing req (d far-side delay + 2 synchroniser flops), so a round trip takes 7+2d cycles.
  // A phase fails when that wait exceeds the last counted cycle T-1; the error then shows
  // T+1 cycles after the accept.
  function automatic exp_t model(input int i, input logic [7:0] d, input int c);
    exp_t e;
    int   t;
    t = tmo_of(i);
    e.data = d;
    if (!ack_mode[i] && (t == 0 || ack_dly[i] + 2 <= t - 1)) begin
      e.timeout = 1'b0;
      e.when    = c + 7 + 2 * ack_dly[i];
    end else if (t > 0) begin
      e.timeout = 1'b1;
      e.when    = c + 1 + t;
    end else begin
      e.timeout = 1'b0;
      e.when    = -1;
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    logic ev_done;
    logic ev_err;
    for (int i = 0; i < 3; i++) begin
      ev_done = done[i];
      ev_err  = tmo_err[i] && !prev_err[i];
      if (!rst[i]) begin
        if (ev_done || ev_err) begin
          if (sb_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: inst %0d done=%0b err_rise=%0b, required none",
                     i, ev_done, ev_err);
          end else begin
            e = sb_q[i].pop_front();
            chk($sformatf("event_is_done_i%0d", i), 64'(ev_done), 64'(!e.timeout));
            chk($sformatf("event_cycle_i%0d", i), 64'(cyc), 64'(e.when));
            if (ev_done) chk($sformatf("done_data_i%0d", i), 64'(xfer_data[i]), 64'(e.data));
            if (ev_err) chk($sformatf("req_after_timeout_i%0d", i), 64'(xfer_req[i]), 64'(0));
          end
        end
        if (xfer_req[i] && sb_q[i].size() != 0)
          chk($sformatf("data_while_req_i%0d", i), 64'(xfer_data[i]), 64'(sb_q[i][0].data));
      end
      prev_err[i] = tmo_err[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit hold, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready[i]) begin
        got = 1'b1;
        acc = cyc;
        sb_q[i].push_back(model(i, d, cyc));
      end
      tick();
    end
    if (!hold) in_valid[i] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: inst %0d word 0x%0h ready=0 for 200 cycles, required 1", i, d);
    end
  endtask

  task automatic drain(input int i, input int budget);
    for (int n = 0; n < budget && sb_q[i].size() != 0; n++) tick();
    if (sb_q[i].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_i%0d: %0d outcomes pending, required 0", i, sb_q[i].size());
    end
  endtask

  // Let any old req history age out before the echo delay changes.
  task automatic set_delay(input int i, input int d);
    repeat (33) tick();
    ack_dly[i] = d;
  endtask

  task automatic do_reset(input int i, input int n);
    rst[i] = 1'b1;
    sb_q[i].delete();
    repeat (n) tick();
    rst[i] = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin : stim
    int acc;
    int acc2;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; in_data[i] = '0;
      ack_mode[i] = 1'b0; ack_force[i] = 1'b0; ack_dly[i] = 0; prev_err[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_req_i%0d", i), 64'(xfer_req[i]), 64'(0));
      chk($sformatf("rst_data_i%0d", i), 64'(xfer_data[i]), 64'(0));
      chk($sformatf("rst_done_i%0d", i), 64'(done[i]), 64'(0));
      chk($sformatf("rst_err_i%0d", i), 64'(tmo_err[i]), 64'(0));
      chk($sformatf("rst_busy_i%0d", i), 64'(busy[i]), 64'(0));
      chk($sformatf("rst_ready_i%0d", i), 64'(in_ready[i]), 64'(1));
    end
    tick();

    // Single word, zero-delay echo.
    send(0, 8'hA5, 1'b0, acc);
    drain(0, 100);

    // Back-to-back with valid held: second accept lands on the first done cycle.
    send(0, 8'h01, 1'b1, acc);
    send(0, 8'h02, 1'b0, acc2);
    chk("b2b_accept_gap", 64'(acc2 - acc), 64'(7));
    drain(0, 100);

    // Long ack delay with timeout disabled.
    set_delay(0, 20);
    send(0, 8'hC3, 1'b0, acc);
    drain(0, 200);
    chk("long_delay_err", 64'(tmo_err[0]), 64'(0));

    // Randomised words and delays on the no-timeout instance.
    for (int r = 0; r < 4; r++) begin
      set_delay(0, int'($urandom_range(0, 3)));
      for (int k = 0; k < 4; k++) begin
        send(0, 8'($urandom), 1'b0, acc);
        repeat ($urandom_range(0, 3)) tick();
      end
      drain(0, 200);
    end

    // Timeout=4: random words at delays that just meet the deadline.
    for (int k = 0; k < 4; k++) begin
      set_delay(2, int'($urandom_range(0, 1)));
      send(2, 8'($urandom), 1'b0, acc);
      drain(2, 100);
    end
    // Ack lands on the exact expiry cycle in both phases.
    set_delay(2, 1);
    send(2, 8'h5A, 1'b0, acc);
    drain(2, 100);
    chk("exact_expiry_err", 64'(tmo_err[2]), 64'(0));
    // One cycle later misses it.
    set_delay(2, 2);
    send(2, 8'h6B, 1'b0, acc);
    drain(2, 100);
    chk("late_ack_err", 64'(tmo_err[2]), 64'(1));
    do_reset(2, 2);

    // Timeout=8 with ack never rising.
    ack_mode[1] = 1'b1;
    ack_force[1] = 1'b0;
    send(1, 8'h99, 1'b1, acc);
    drain(1, 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fault_ready", 64'(in_ready[1]), 64'(0));
      chk("fault_busy", 64'(busy[1]), 64'(1));
      tick();
    end
    in_valid[1] = 1'b0;
    do_reset(1, 1);
    @(negedge clk);
    chk("post_fault_rst_err", 64'(tmo_err[1]), 64'(0));
    chk("post_fault_rst_ready", 64'(in_ready[1]), 64'(1));
    tick();

    // Reset in WAIT_ACK_HI while the far ack is held high.
    set_delay(0, 0);
    send(0, 8'h77, 1'b0, acc);
    ack_mode[0] = 1'b1;
    ack_force[0] = 1'b1;
    rst[0] = 1'b1;
    sb_q[0].delete();
    tick();
    @(negedge clk);
    chk("midrst_req", 64'(xfer_req[0]), 64'(0));
    chk("midrst_data", 64'(xfer_data[0]), 64'(0));
    chk("midrst_busy", 64'(busy[0]), 64'(0));
    repeat (3) tick();
    rst[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ack_high_ready", 64'(in_ready[0]), 64'(0));
      chk("ack_high_busy", 64'(busy[0]), 64'(0));
      tick();
    end
    in_valid[0] = 1'b0;
    ack_force[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ack_fall_ready_%0d", k), 64'(in_ready[0]), 64'(k == 2));
      if (k < 2) tick();
    end
    tick();
    ack_mode[0] = 1'b0;
    send(0, 8'h3C, 1'b0, acc);
    drain(0, 100);

    for (int i = 0; i < 3; i++) drain(i, 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
